// File: rtl/mithril_addsub_limb.sv
`default_nettype none
// ============================================================================
// Module      : mithril_addsub_limb
// Description : Limb-serial constant-time add/sub and modular add/sub.
// Revision    : 1.0 - initial release
// ============================================================================
module mithril_addsub_limb #(
  parameter int WIDTH = 256,
  parameter int LIMB  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             done,
  output logic             busy,
  output logic             error
);

  localparam int            NLIMBS = WIDTH / LIMB;
  localparam int            CW     = (NLIMBS > 1) ? $clog2(NLIMBS) : 1;
  localparam logic [CW-1:0] LAST   = CW'(NLIMBS - 1);
  localparam logic [1:0]    OP_MODSUB = 2'b11;

  generate
    if ((WIDTH % LIMB) != 0 || LIMB < 8) begin : g_bad_params
      $error("mithril_addsub_limb: WIDTH must be a multiple of LIMB and LIMB >= 8");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PASS1  = 3'd1,
    S_PASS2  = 3'd2,
    S_SELECT = 3'd3,
    S_WIPE   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] t_q;
  logic             c_q;
  logic             c1_q;
  logic             c2_q;
  logic             pzero_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             done_q;
  logic             busy_q;
  logic             error_q;

  logic [LIMB-1:0]  x_d;
  logic [LIMB-1:0]  y_d;
  logic [LIMB:0]    sum_d;
  logic [WIDTH-1:0] r_shift_d;
  logic [WIDTH-1:0] r_rot_d;
  logic [WIDTH-1:0] t_shift_d;
  logic             use_t_d;
  logic [WIDTH-1:0] mask_d;
  logic [WIDTH-1:0] sel_d;

  // One shared limb adder: PASS1 sums a/b, PASS2 sums r/p.
  always_comb begin
    x_d = a_q[LIMB-1:0];
    y_d = op_q[0] ? ~b_q[LIMB-1:0] : b_q[LIMB-1:0];
    if (state_q == S_PASS2) begin
      x_d = r_q[LIMB-1:0];
      y_d = (op_q == OP_MODSUB) ? p_q[LIMB-1:0] : ~p_q[LIMB-1:0];
    end
    sum_d = {1'b0, x_d} + {1'b0, y_d} + {{LIMB{1'b0}}, c_q};
  end

  // New limbs enter at the top so the LSB limb ends up at bit 0 after NLIMBS steps.
  assign r_shift_d = (r_q >> LIMB) | (WIDTH'(sum_d[LIMB-1:0]) << (WIDTH - LIMB));
  assign r_rot_d   = (r_q >> LIMB) | (WIDTH'(r_q[LIMB-1:0]) << (WIDTH - LIMB));
  assign t_shift_d = (t_q >> LIMB) | (WIDTH'(sum_d[LIMB-1:0]) << (WIDTH - LIMB));

  assign use_t_d = (op_q[1] & ~op_q[0] & (c1_q | c2_q)) | (op_q[1] & op_q[0] & ~c1_q);
  assign mask_d  = {WIDTH{use_t_d}};
  assign sel_d   = (t_q & mask_d) | (r_q & ~mask_d);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      r_q      <= '0;
      t_q      <= '0;
      c_q      <= 1'b0;
      c1_q     <= 1'b0;
      c2_q     <= 1'b0;
      pzero_q  <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          busy_q <= start;
          if (start) begin
            state_q <= S_PASS1;
            cnt_q   <= '0;
            op_q    <= op;
            a_q     <= operand_a;
            b_q     <= operand_b;
            p_q     <= modulus;
            pzero_q <= ~|modulus;
            c_q     <= op[0];
          end
        end
        S_PASS1: begin
          a_q   <= a_q >> LIMB;
          b_q   <= b_q >> LIMB;
          r_q   <= r_shift_d;
          c_q   <= sum_d[LIMB];
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= S_PASS2;
            cnt_q   <= '0;
            c1_q    <= sum_d[LIMB];
            // Subtracting p needs the +1 of two's complement; adding p does not.
            c_q     <= (op_q != OP_MODSUB);
          end
        end
        S_PASS2: begin
          p_q   <= p_q >> LIMB;
          r_q   <= r_rot_d;
          t_q   <= t_shift_d;
          c_q   <= sum_d[LIMB];
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= S_SELECT;
            cnt_q   <= '0;
            c2_q    <= sum_d[LIMB];
          end
        end
        S_SELECT: begin
          result_q <= sel_d;
          carry_q  <= ~op_q[1] & (c1_q ^ op_q[0]);
          error_q  <= op_q[1] & pzero_q;
          state_q  <= S_WIPE;
        end
        S_WIPE: begin
          op_q    <= '0;
          a_q     <= '0;
          b_q     <= '0;
          p_q     <= '0;
          r_q     <= '0;
          t_q     <= '0;
          c_q     <= 1'b0;
          c1_q    <= 1'b0;
          c2_q    <= 1'b0;
          pzero_q <= 1'b0;
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign result    = result_q;
  assign carry_out = carry_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign error     = error_q;

endmodule
`default_nettype wire

// File: tb/tb_mithril_addsub_limb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mithril_addsub_limb
// Description : Table-driven bench for mithril_addsub_limb at 256/32.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mithril_addsub_limb;

  localparam int LAT = 19;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [255:0] operand_a;
  logic [255:0] operand_b;
  logic [255:0] modulus;
  logic [255:0] result;
  logic         carry_out;
  logic         done;
  logic         busy;
  logic         error;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0]   op;
    logic [255:0] a;
    logic [255:0] b;
    logic [255:0] p;
    logic [255:0] res;
    logic         cout;
    logic         err;
    bit           chk_res;
  } vec_t;

  vec_t vecs[12];

  mithril_addsub_limb #(.WIDTH(256), .LIMB(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .modulus   (modulus),
    .result    (result),
    .carry_out (carry_out),
    .done      (done),
    .busy      (busy),
    .error     (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs one op; when pulse is set, a stray start is driven a few cycles into PASS1.
  task automatic run_vec(input vec_t v, input string name, input bit pulse);
    int  cyc;
    bit  seen;
    @(negedge clk);
    op = v.op; operand_a = v.a; operand_b = v.b; modulus = v.p; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (done) seen = 1'b1;
      else if (pulse && cyc == 3) begin
        start = 1'b1; op = 2'b01; operand_a = 256'd100; operand_b = 256'd1;
      end else if (pulse && cyc == 4) start = 1'b0;
    end
    chk({name, " latency"}, 256'(cyc), 256'(LAT));
    if (v.chk_res) chk({name, " result"}, result, v.res);
    chk({name, " carry"}, 256'(carry_out), 256'(v.cout));
    chk({name, " error"}, 256'(error), 256'(v.err));
    chk({name, " busy@done"}, 256'(busy), 256'd1);
    @(posedge clk); #1;
    chk({name, " done width"}, 256'(done), 256'd0);
    chk({name, " busy after"}, 256'(busy), 256'd0);
  endtask

  initial begin
    logic [255:0] p;
    logic [255:0] ones;
    int  first_done;
    int  second_done;
    bit  got_done;
    p    = (256'd1 << 255) - 256'd19;
    ones = '1;

    vecs[0]  = '{2'b00, ones, 256'd1, p, 256'd0, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{2'b01, 256'd0, 256'd1, p, ones, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{2'b01, 256'd9, 256'd4, p, 256'd5, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{2'b10, p - 256'd1, 256'd2, p, 256'd1, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{2'b11, 256'd3, 256'd5, p, p - 256'd2, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{2'b11, 256'd5, 256'd3, p, 256'd2, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{2'b00, (256'd1 << 128) - 256'd1, 256'd1, p, 256'd1 << 128, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{2'b10, p - 256'd1, p - 256'd1, p, p - 256'd2, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{2'b01, 256'hDEAD_BEEF, 256'hDEAD_BEEF, p, 256'd0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{2'b00, 256'd7, 256'd8, 256'd0, 256'd15, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{2'b10, 256'd5, 256'd7, 256'd0, 256'd0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{2'b10, 256'd5, 256'd7, p, 256'd12, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; start = 1'b0; op = 2'b00;
    operand_a = '0; operand_b = '0; modulus = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset result", result, 256'd0);
    chk("reset carry", 256'(carry_out), 256'd0);
    chk("reset done", 256'(done), 256'd0);
    chk("reset busy", 256'(busy), 256'd0);
    chk("reset error", 256'(error), 256'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i), 1'b0);
    end

    // Reset landing in PASS2 must abort silently.
    @(negedge clk);
    op = 2'b00; operand_a = 256'd40; operand_b = 256'd2; modulus = p; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midreset busy", 256'(busy), 256'd0);
    chk("midreset result", result, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    got_done = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done) got_done = 1'b1;
    end
    chk("midreset no done", 256'(got_done), 256'd0);
    run_vec('{2'b00, 256'd1, 256'd1, p, 256'd2, 1'b0, 1'b0, 1'b1}, "post-reset add", 1'b0);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    rst_n = 1'b0; start = 1'b1; op = 2'b00; operand_a = 256'd1; operand_b = 256'd1;
    @(posedge clk); #1;
    chk("reset-vs-start busy", 256'(busy), 256'd0);
    @(negedge clk);
    start = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset-vs-start idle", 256'(busy), 256'd0);

    run_vec('{2'b00, 256'd9, 256'd4, p, 256'd13, 1'b0, 1'b0, 1'b1}, "stray start", 1'b1);
    got_done = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (done) got_done = 1'b1;
    end
    chk("stray start no 2nd op", 256'(got_done), 256'd0);

    // Start held high: two ops spaced by 2*NLIMBS+4 cycles.
    @(negedge clk);
    op = 2'b00; operand_a = 256'd3; operand_b = 256'd4; modulus = p; start = 1'b1;
    @(posedge clk); #1;
    first_done = -1; second_done = -1;
    for (int c = 1; c <= 60 && second_done < 0; c++) begin
      @(posedge clk); #1;
      if (done) begin
        if (first_done < 0) first_done = c;
        else begin
          second_done = c;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("b2b first done", 256'(first_done), 256'(LAT));
    chk("b2b second done", 256'(second_done), 256'(LAT + 20));
    chk("b2b result", result, 256'd7);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b idle after", 256'(busy), 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mithril_addsub_limb.md
MITHRIL_ADDSUB_LIMB -- requirements
Module: mithril_addsub_limb

Interface
REQ-001 SHALL have parameter WIDTH, default 256, operand/result width in bits.
REQ-002 SHALL have parameter LIMB, default 32, limb width processed per cycle; NLIMBS = WIDTH/LIMB.
REQ-003 SHALL provide clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL provide rst_n  input  1  reset; synchronous and active-low.
REQ-005 SHALL provide start  input  1  request; sampled only in IDLE.
REQ-006 SHALL provide op  input  2  operation: 00 ADD, 01 SUB, 10 MODADD, 11 MODSUB; captured with start.
REQ-007 SHALL provide operand_a, operand_b, modulus  input  WIDTH each  operands and modulus p; captured with start.
REQ-008 SHALL provide result  output  WIDTH  registered result.
REQ-009 SHALL provide carry_out  output  1  ADD carry / SUB borrow; 0 for modular ops.
REQ-010 SHALL provide done  output  1  one-cycle completion pulse.
REQ-011 SHALL provide busy  output  1  high from accepted start until the DONE cycle inclusive.
REQ-012 SHALL provide error  output  1  valid with done; high for a modular op with modulus == 0.

Function
REQ-013 SHALL reject at elaboration any WIDTH not an integer multiple of LIMB, or LIMB < 8.
REQ-014 SHALL implement states IDLE, PASS1, PASS2, SELECT, WIPE, DONE.
REQ-015 SHALL transition: IDLE->PASS1 on start; PASS1->PASS2 after NLIMBS cycles; PASS2->SELECT after NLIMBS cycles; SELECT->WIPE->DONE->IDLE, one cycle each.
REQ-016 SHALL have fixed latency 2*NLIMBS+3 cycles from the accepting edge to done high (19 at defaults), independent of op, operand values, carries and the selected output.
REQ-017 SHALL ignore start outside IDLE; start held high yields back-to-back ops every 2*NLIMBS+4 cycles.
REQ-018 PASS1 SHALL compute r = a+b (ADD, MODADD) or r = a+~b+1 (SUB, MODSUB) one limb per cycle, LSB limb first, with a registered carry chain; c1 = final carry.
REQ-019 PASS2 SHALL compute t = r-p (ADD, SUB, MODADD) or t = r+p (MODSUB) limb-serially; c2 = final carry. PASS2 runs for all ops.
REQ-020 SELECT SHALL choose the result by a mask derived from carries, never by data-dependent branching or enable: ADD/SUB -> r; MODADD -> t if (c1 | c2) else r; MODSUB -> t if !c1 else r.
REQ-021 SHALL set carry_out = c1 for ADD, !c1 for SUB, 0 for MODADD/MODSUB, registered in SELECT.
REQ-022 Modular results SHALL be correct for inputs a,b < p; other inputs give an unspecified, still fixed-latency result.
REQ-023 SHALL compute the modulus==0 test at capture by OR-reduction; error registered in SELECT; error = 0 for ADD/SUB.
REQ-024 WIPE SHALL zero all operand, modulus, r, t and carry registers in one cycle.
REQ-025 SHALL assert done for exactly the DONE cycle; result, carry_out and error SHALL hold until SELECT of the next op.

Reset
REQ-026 When rst_n is low at a rising edge, the next state SHALL be IDLE with result=0, carry_out=0, done=0, busy=0, error=0 and every internal register zeroed.
REQ-027 Reset mid-operation SHALL abort without producing done; the next start SHALL run a full-latency op.
REQ-028 Reset SHALL take priority over start at the same edge.

Verification (WIDTH=256, LIMB=32, p = 2^255-19)
REQ-029 ADD a=2^256-1, b=1 -> result 0, carry_out 1, done exactly 19 cycles after the accepting edge.
REQ-030 SUB a=0, b=1 -> result 2^256-1, carry_out 1; SUB a=9, b=4 -> result 5, carry_out 0.
REQ-031 MODADD a=p-1, b=2 -> result 1; MODADD a=5, b=7 -> result 12; both carry_out 0, both done at cycle 19.
REQ-032 MODSUB a=3, b=5 -> result p-2; MODSUB a=5, b=3 -> result 2.
REQ-033 rst_n low for one cycle during PASS2 -> busy 0, result 0 on the next cycle, no done; a following ADD 1+1 -> result 2 at cycle 19.
REQ-034 start pulsed during PASS1 is ignored, with no latency change; MODADD with modulus 0 -> error 1 coincident with done.
